heap_feeder: RTL and testbench
==============================

HEAP_FEEDER -- requirements
Module: heap_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, heap word width.
REQ-002 SHALL have parameter KEY_WIDTH, default 16, sort-key width in word bits [KEY_WIDTH-1:0].
REQ-003 SHALL have parameter NLEVELS, default 2, heap depth; HEAP_SIZE = 2^(NLEVELS+1)-1.
REQ-004 SHALL have parameter ISSUE_GAP, default 1, minimum idle cycles between consecutive h_en pulses.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse that begins a frame; ignored outside IDLE.
REQ-008 s_valid  in  1  upstream item valid.
REQ-009 s_ready  out  1  item accepted when s_valid&&s_ready.
REQ-010 s_key  in  KEY_WIDTH  item sort key.
REQ-011 s_payload  in  DATA_WIDTH-2-KEY_WIDTH  item tag/payload.
REQ-012 s_last  in  1  marks the final item of the frame.
REQ-013 h_din  out  DATA_WIDTH  heap input word.
REQ-014 h_en  out  1  heap insert strobe.
REQ-015 h_init  out  1  heap initialise strobe.
REQ-016 h_flush  out  1  heap flush strobe.
REQ-017 h_valid  in  1  heap output-valid, counted only.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 frame_done  out  1  one-cycle pulse at end of drain.
REQ-020 out_count  out  NLEVELS+8  heap outputs seen in the frame, stable from frame_done until next start.
REQ-021 overflow  out  1  sticky: more than HEAP_SIZE items accepted in the frame.

Function
REQ-022 SHALL implement states IDLE, INIT, FILL, FLUSH, DRAIN, all outputs registered.
REQ-023 IDLE->INIT on start; INIT lasts one cycle with h_init=1, clears in_count, out_count, overflow, gap counter; INIT->FILL.
REQ-024 In FILL, s_ready SHALL be 1 only when the gap counter is zero; s_ready=0 in all other states.
REQ-025 On accept: next cycle h_en=1, h_din={2'b00, s_payload, s_key}; gap counter loads ISSUE_GAP; decrements to zero once per cycle.
REQ-026 h_din SHALL hold its last value when h_en=0; flag bits never 2'b01 or 2'b11.
REQ-027 in_count increments per accept, saturating at all-ones; overflow sets when in_count would exceed HEAP_SIZE.
REQ-028 Accept with s_last=1 SHALL move FILL->FLUSH; a single-item frame is legal.
REQ-029 FLUSH SHALL wait for the gap counter to reach zero, then assert h_flush for exactly one cycle and go to DRAIN.
REQ-030 DRAIN SHALL last exactly 2*HEAP_SIZE+2 cycles (drain counter), then pulse frame_done and return to IDLE.
REQ-031 out_count increments on each h_valid=1 cycle in FILL, FLUSH and DRAIN, saturating; h_valid in IDLE/INIT ignored.
REQ-032 h_en, h_init and h_flush SHALL be mutually exclusive in every cycle.
REQ-033 start during any non-IDLE state SHALL be ignored; s_valid outside FILL is not accepted.

Reset
REQ-034 On rstn=0: state IDLE, s_ready=0, h_din=0, h_en=0, h_init=0, h_flush=0, busy=0, frame_done=0, out_count=0, overflow=0, all counters 0.
REQ-035 Reset asserted mid-frame SHALL abort immediately with no h_flush issued; next frame requires start.

Verification
REQ-036 start, 3 items keys 5,2,9 (last on 9), ISSUE_GAP=1 -> h_init one cycle, h_en pulses spaced 2 cycles with h_din low 16 bits 5,2,9 and bits[31:30]=00, one h_flush, frame_done 2*7+2 cycles later.
REQ-037 s_valid held high continuously, ISSUE_GAP=3 -> s_ready high one cycle in four, h_en never closer than 4 cycles.
REQ-038 8 items with NLEVELS=2 -> overflow=1 after 8th accept, remains 1 until next INIT.
REQ-039 single item with s_last on first beat -> FILL->FLUSH directly, exactly one h_en and one h_flush.
REQ-040 rstn low during DRAIN -> all outputs at reset values asynchronously, no frame_done; subsequent start runs a clean frame.
REQ-041 drive h_valid on 4 cycles during DRAIN and 1 in IDLE -> out_count=4 at frame_done.

Source files
------------

// File: rtl/heap_feeder.sv
// heap_feeder: takes a frame of keyed items from an upstream stream and pushes
// them into a hardware heap. The sequence is initialise, paced inserts, flush,
// then a fixed-length drain. Heap output strobes are counted, and the module
// flags a frame that holds more items than the heap can store.
module heap_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEY_WIDTH  = 16,
  parameter int unsigned NLEVELS    = 2,
  parameter int unsigned ISSUE_GAP  = 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [KEY_WIDTH-1:0]               s_key,
  input  logic [DATA_WIDTH-KEY_WIDTH-3:0]    s_payload,
  input  logic                               s_last,
  output logic [DATA_WIDTH-1:0]              h_din,
  output logic                               h_en,
  output logic                               h_init,
  output logic                               h_flush,
  input  logic                               h_valid,
  output logic                               busy,
  output logic                               frame_done,
  output logic [NLEVELS+7:0]                 out_count,
  output logic                               overflow
);

  localparam int unsigned HEAP_SIZE = (2 ** (NLEVELS + 1)) - 1;
  localparam int unsigned CW        = NLEVELS + 8;
  localparam int unsigned GW        = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
  localparam int unsigned DRAIN_LEN = 2 * HEAP_SIZE + 2;
  localparam int unsigned DW        = $clog2(DRAIN_LEN);

  localparam logic [GW-1:0] GAP_LOAD    = GW'(ISSUE_GAP);
  localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_LEN - 1);
  localparam logic [CW-1:0] HEAP_SIZE_C = CW'(HEAP_SIZE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]            r_state, w_state_d;
  logic [GW-1:0]         r_gap, w_gap_d;
  logic [CW-1:0]         r_in_count, w_in_d;
  logic [CW-1:0]         r_out_count, w_out_d;
  logic [DW-1:0]         r_drain, w_drain_d;
  logic [DATA_WIDTH-1:0] r_h_din, w_din_d;
  logic                  r_overflow, w_ovf_d;
  logic                  r_s_ready, w_ready_d;
  logic                  r_h_en, w_en_d;
  logic                  r_h_init, w_init_d;
  logic                  r_h_flush, w_flush_d;
  logic                  r_busy, w_busy_d;
  logic                  r_done, w_done_d;
  logic                  w_accept;
  logic                  w_counting;

  // Next-state logic for the frame sequencer, counters and registered outputs.
  always_comb begin
    w_state_d = r_state;
    w_gap_d   = r_gap;
    w_in_d    = r_in_count;
    w_out_d   = r_out_count;
    w_ovf_d   = r_overflow;
    w_drain_d = r_drain;
    w_din_d   = r_h_din;
    w_en_d    = 1'b0;
    w_init_d  = 1'b0;
    w_flush_d = 1'b0;
    w_done_d  = 1'b0;

    // s_ready is registered, so it already encodes FILL with an expired gap.
    w_accept   = (r_state == S_FILL) && r_s_ready && s_valid;
    w_counting = (r_state == S_FILL) || (r_state == S_FLUSH) || (r_state == S_DRAIN);

    if (r_gap != '0) begin
      w_gap_d = r_gap - GW'(1);
    end
    if (w_counting && h_valid && (r_out_count != '1)) begin
      w_out_d = r_out_count + CW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_d = S_INIT;
          w_init_d  = 1'b1;
        end
      end
      S_INIT: begin
        w_state_d = S_FILL;
        w_gap_d   = '0;
        w_in_d    = '0;
        w_out_d   = '0;
        w_ovf_d   = 1'b0;
        w_drain_d = '0;
      end
      S_FILL: begin
        if (w_accept) begin
          w_en_d  = 1'b1;
          w_din_d = {2'b00, s_payload, s_key};
          w_gap_d = GAP_LOAD;
          if (r_in_count != '1) begin
            w_in_d = r_in_count + CW'(1);
          end
          // This accept makes the count exceed what the heap can hold.
          if (r_in_count >= HEAP_SIZE_C) begin
            w_ovf_d = 1'b1;
          end
          if (s_last) begin
            w_state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (r_gap == '0) begin
          w_flush_d = 1'b1;
          w_state_d = S_DRAIN;
          w_drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_done_d  = 1'b1;
          w_state_d = S_IDLE;
          w_drain_d = '0;
        end else begin
          w_drain_d = r_drain + DW'(1);
        end
      end
      default: w_state_d = S_IDLE;
    endcase

    w_ready_d = (w_state_d == S_FILL) && (w_gap_d == '0);
    w_busy_d  = (w_state_d != S_IDLE);
  end

  // State and output registers; reset aborts a frame without any heap strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_gap       <= '0;
      r_in_count  <= '0;
      r_out_count <= '0;
      r_overflow  <= 1'b0;
      r_drain     <= '0;
      r_h_din     <= '0;
      r_s_ready   <= 1'b0;
      r_h_en      <= 1'b0;
      r_h_init    <= 1'b0;
      r_h_flush   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_gap       <= w_gap_d;
      r_in_count  <= w_in_d;
      r_out_count <= w_out_d;
      r_overflow  <= w_ovf_d;
      r_drain     <= w_drain_d;
      r_h_din     <= w_din_d;
      r_s_ready   <= w_ready_d;
      r_h_en      <= w_en_d;
      r_h_init    <= w_init_d;
      r_h_flush   <= w_flush_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

  assign s_ready    = r_s_ready;
  assign h_din      = r_h_din;
  assign h_en       = r_h_en;
  assign h_init     = r_h_init;
  assign h_flush    = r_h_flush;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign out_count  = r_out_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_heap_feeder.sv
// Bench for heap_feeder. Accepted items are pushed to a scoreboard and popped
// on each h_en. A second instance with ISSUE_GAP=3 checks insert pacing.
module tb_heap_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_key = '0;
  logic [13:0] s_payload = '0;
  logic        s_last = 1'b0;
  logic [31:0] h_din;
  logic        h_en, h_init, h_flush;
  logic        h_valid = 1'b0;
  logic        busy, frame_done, overflow;
  logic [9:0]  out_count;

  logic        g_start = 1'b0;
  logic        g_s_valid = 1'b0;
  logic        g_s_ready;
  logic [15:0] g_s_key = 16'h00AB;
  logic [13:0] g_s_payload = 14'h0011;
  logic        g_s_last = 1'b0;
  logic [31:0] g_h_din;
  logic        g_h_en, g_h_init, g_h_flush;
  logic        g_busy, g_frame_done, g_overflow;
  logic [9:0]  g_out_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_din = '0;
  bit          last_acc;
  int cyc = 0;
  int n_hen, n_flush, n_done, flush_at, done_at, last_hen, min_gap, max_gap;

  always #5 clk = ~clk;

  heap_feeder u_dut (
    .clk(clk), .rstn(rstn), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_key(s_key), .s_payload(s_payload), .s_last(s_last), .h_din(h_din), .h_en(h_en),
    .h_init(h_init), .h_flush(h_flush), .h_valid(h_valid), .busy(busy),
    .frame_done(frame_done), .out_count(out_count), .overflow(overflow)
  );

  heap_feeder #(.ISSUE_GAP(3)) u_dut_g3 (
    .clk(clk), .rstn(rstn), .start(g_start), .s_valid(g_s_valid), .s_ready(g_s_ready),
    .s_key(g_s_key), .s_payload(g_s_payload), .s_last(g_s_last), .h_din(g_h_din),
    .h_en(g_h_en), .h_init(g_h_init), .h_flush(g_h_flush), .h_valid(1'b0), .busy(g_busy),
    .frame_done(g_frame_done), .out_count(g_out_count), .overflow(g_overflow)
  );

  task automatic clear_stats();
    n_hen = 0; n_flush = 0; n_done = 0; flush_at = 0; done_at = 0;
    last_hen = -1; min_gap = 1000; max_gap = 0;
  endtask

  // One clock: record a pending accept, advance, then check strobes and the scoreboard.
  task automatic tick();
    logic [31:0] w;
    last_acc = s_valid && s_ready;
    if (last_acc) exp_q.push_back({2'b00, s_payload, s_key});
    @(posedge clk); #1;
    cyc++;
    checks++;
    if (int'(h_en) + int'(h_init) + int'(h_flush) > 1) begin
      errors++;
      $display("FAIL strobe_excl: en=%b init=%b flush=%b, required at most one", h_en, h_init,
               h_flush);
    end
    checks++;
    if (h_en) begin
      n_hen++;
      if (last_hen >= 0) begin
        if (cyc - last_hen < min_gap) min_gap = cyc - last_hen;
        if (cyc - last_hen > max_gap) max_gap = cyc - last_hen;
      end
      last_hen = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL hen_unexpected: h_en=1 din=%h, required no insert", h_din);
      end else begin
        w = exp_q.pop_front();
        if (h_din !== w) begin
          errors++;
          $display("FAIL h_din: got %h, required %h", h_din, w);
        end
        last_din = w;
      end
    end else if (h_din !== last_din) begin
      errors++;
      $display("FAIL h_din_hold: got %h, required %h", h_din, last_din);
    end
    if (h_flush) begin n_flush++; flush_at = cyc; end
    if (frame_done) begin n_done++; done_at = cyc; end
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (h_init !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL init: h_init=%b busy=%b, required 1 1", h_init, busy);
    end
    tick();
    checks++;
    if (h_init !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_entry: h_init=%b s_ready=%b, required 0 1", h_init, s_ready);
    end
  endtask

  task automatic send_item(input logic [15:0] key, input logic [13:0] pl, input logic last);
    int n;
    s_valid = 1'b1; s_key = key; s_payload = pl; s_last = last;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (!last_acc) begin
      errors++;
      $display("FAIL accept_timeout: key %h not accepted, required accept", key);
    end
  endtask

  task automatic wait_flush();
    int n;
    n = 0;
    while (n_flush == 0 && n < 100) begin tick(); n++; end
    checks++;
    if (n_flush == 0) begin
      errors++;
      $display("FAIL flush_timeout: no h_flush, required one");
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n_done == 0 && n < 200) begin tick(); n++; end
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL done_timeout: no frame_done, required one");
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, h_en, h_init, h_flush, busy, frame_done, overflow} !== 7'b0 ||
        h_din !== 32'h0 || out_count !== 10'h0) begin
      errors++;
      $display("FAIL reset_state: flags=%b din=%h cnt=%0d, required all zero",
               {s_ready, h_en, h_init, h_flush, busy, frame_done, overflow}, h_din, out_count);
    end
    @(posedge clk); #3 rstn = 1'b1;
  endtask

  task automatic test_basic();
    clear_stats();
    start_frame();
    send_item(16'd5, 14'h0AA1, 1'b0);
    send_item(16'd2, 14'h1553, 1'b0);
    send_item(16'd9, 14'h3FFF, 1'b1);
    wait_done();
    checks++;
    if (n_hen != 3 || n_flush != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_counts: hen=%0d flush=%0d left=%0d, required 3 1 0", n_hen, n_flush,
               exp_q.size());
    end
    checks++;
    if (min_gap != 2 || max_gap != 2) begin
      errors++;
      $display("FAIL basic_spacing: min=%0d max=%0d, required 2 2", min_gap, max_gap);
    end
    checks++;
    if (done_at - flush_at != 16) begin
      errors++;
      $display("FAIL drain_len: %0d cycles, required 16", done_at - flush_at);
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b0 || out_count !== 10'd0) begin
      errors++;
      $display("FAIL basic_end: busy=%b ovf=%b cnt=%0d, required 0 0 0", busy, overflow,
               out_count);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: frame_done=%b, required 0", frame_done);
    end
  endtask

  task automatic test_overflow();
    clear_stats();
    start_frame();
    for (int i = 1; i <= 8; i++) begin
      send_item(16'(i * 3), 14'(i), (i == 8));
      if (i == 7) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early: overflow=%b after 7, required 0", overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: overflow=%b after 8, required 1", overflow);
    end
    wait_done();
    checks++;
    if (overflow !== 1'b1 || n_hen != 8) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b hen=%0d, required 1 8", overflow, n_hen);
    end
    repeat (3) tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_idle: overflow=%b, required 1", overflow);
    end
  endtask

  task automatic test_single();
    clear_stats();
    start_frame();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: overflow=%b after init, required 0", overflow);
    end
    send_item(16'hFFFF, 14'h0000, 1'b1);
    start = 1'b1;  // must be ignored while busy
    tick();
    start = 1'b0;
    wait_done();
    checks++;
    if (n_hen != 1 || n_flush != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single: hen=%0d flush=%0d left=%0d, required 1 1 0", n_hen, n_flush,
               exp_q.size());
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || h_init !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: busy=%b h_init=%b, required 0 0", busy, h_init);
    end
  endtask

  task automatic test_out_count();
    clear_stats();
    start_frame();
    send_item(16'd42, 14'd7, 1'b1);
    wait_flush();
    h_valid = 1'b1;
    repeat (4) tick();
    h_valid = 1'b0;
    wait_done();
    checks++;
    if (out_count !== 10'd4) begin
      errors++;
      $display("FAIL out_count: got %0d at done, required 4", out_count);
    end
    h_valid = 1'b1;
    tick();
    h_valid = 1'b0;
    tick();
    checks++;
    if (out_count !== 10'd4) begin
      errors++;
      $display("FAIL out_count_idle: got %0d, required 4", out_count);
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    start_frame();
    send_item(16'd7, 14'd1, 1'b1);
    wait_flush();
    h_valid = 1'b1;
    repeat (3) tick();
    h_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({s_ready, h_en, h_init, h_flush, busy, frame_done, overflow} !== 7'b0 ||
        h_din !== 32'h0 || out_count !== 10'h0) begin
      errors++;
      $display("FAIL async_reset: flags=%b din=%h cnt=%0d, required all zero",
               {s_ready, h_en, h_init, h_flush, busy, frame_done, overflow}, h_din, out_count);
    end
    last_din = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    clear_stats();
    repeat (30) tick();
    checks++;
    if (n_done != 0 || n_flush != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: done=%0d flush=%0d busy=%b, required 0 0 0", n_done, n_flush,
               busy);
    end
    start_frame();
    send_item(16'd3, 14'h2222, 1'b1);
    wait_done();
    checks++;
    if (n_hen != 1 || n_flush != 1 || done_at - flush_at != 16) begin
      errors++;
      $display("FAIL clean_frame: hen=%0d flush=%0d drain=%0d, required 1 1 16", n_hen, n_flush,
               done_at - flush_at);
    end
  endtask

  task automatic test_gap3();
    int rc, hc, lh, mg, n;
    rc = 0; hc = 0; lh = -1; mg = 1000;
    g_start = 1'b1;
    @(posedge clk); #1;
    g_start = 1'b0;
    @(posedge clk); #1;
    g_s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (g_s_ready) rc++;
      if (g_h_en) begin
        hc++;
        if (lh >= 0 && i - lh < mg) mg = i - lh;
        lh = i;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rc != 10 || hc != 10) begin
      errors++;
      $display("FAIL gap3_rate: ready=%0d hen=%0d in 40, required 10 10", rc, hc);
    end
    checks++;
    if (mg != 4) begin
      errors++;
      $display("FAIL gap3_spacing: min=%0d, required 4", mg);
    end
    g_s_last = 1'b1;
    n = 0;
    while (!g_s_ready && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    g_s_valid = 1'b0; g_s_last = 1'b0;
    n = 0;
    while (!g_frame_done && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (g_frame_done !== 1'b1 || g_overflow !== 1'b1) begin
      errors++;
      $display("FAIL gap3_end: done=%b ovf=%b, required 1 1", g_frame_done, g_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_single();
    test_out_count();
    test_reset_mid();
    test_gap3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
